// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit FIFO write port between the keypad scanner and a host byte port.
// Key events become atomic 1- or 3-byte ASCII messages; host bytes never interleave into them.
module uart_tx_arbiter #(
  parameter bit KEY_ASCII = 1'b1,
  parameter bit KEY_EOL   = 1'b1,
  parameter bit FAIR      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_flag,
  input  logic [3:0] key_data,
  input  logic [7:0] host_data,
  input  logic       host_wrreq,
  output logic       host_full,
  output logic       key_drop,
  input  logic       fifo_wrfull,
  output logic [7:0] fifo_data,
  output logic       fifo_wrreq
);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_CR, S_LF, S_HOST} state_t;
  typedef enum logic {G_KEY, G_HOST} grant_t;

  state_t     state;
  grant_t     last_grant;
  logic       kv, hv;
  logic [3:0] key_hold;
  logic [7:0] host_hold;
  logic [7:0] key_char;
  logic       kv_clr, hv_clr;
  logic       grant_key;

  always_comb begin
    if (!KEY_ASCII)
      key_char = {4'h0, key_hold};
    else if (key_hold < 4'd10)
      key_char = 8'h30 + {4'h0, key_hold};
    else
      key_char = 8'h37 + {4'h0, key_hold};
  end

  always_comb begin
    fifo_wrreq = (state != S_IDLE) && !fifo_wrfull;
    host_full  = hv;
    kv_clr     = (state == S_KEY)  && fifo_wrreq;
    hv_clr     = (state == S_HOST) && fifo_wrreq;
    // Keypad wins unless the host is also waiting and round-robin says it is the host's turn.
    grant_key  = kv && (!hv || !FAIR || (last_grant == G_HOST));
  end

  always_comb begin
    fifo_data = '0;
    case (state)
      S_KEY:   fifo_data = key_char;
      S_CR:    fifo_data = 8'h0D;
      S_LF:    fifo_data = 8'h0A;
      S_HOST:  fifo_data = host_hold;
      default: fifo_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= G_HOST;
      kv         <= 1'b0;
      hv         <= 1'b0;
      key_drop   <= 1'b0;
      key_hold   <= '0;
      host_hold  <= '0;
    end else begin
      key_drop <= key_flag && kv && !kv_clr;

      // A key slot freed by this cycle's write may be refilled in the same cycle.
      if (key_flag && (!kv || kv_clr)) begin
        key_hold <= key_data;
        kv       <= 1'b1;
      end else if (kv_clr) begin
        kv <= 1'b0;
      end

      if (host_wrreq && !hv) begin
        host_hold <= host_data;
        hv        <= 1'b1;
      end else if (hv_clr) begin
        hv <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (grant_key) begin
            state      <= S_KEY;
            last_grant <= G_KEY;
          end else if (hv) begin
            state      <= S_HOST;
            last_grant <= G_HOST;
          end
        end
        S_KEY:   if (fifo_wrreq) state <= KEY_EOL ? S_CR : S_IDLE;
        S_CR:    if (fifo_wrreq) state <= S_LF;
        S_LF:    if (fifo_wrreq) state <= S_IDLE;
        S_HOST:  if (fifo_wrreq) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
